// File: rtl/demux_1to4_reg.sv
// demux_1to4_reg
// Registered 1-to-4 stream demultiplexer. One valid/ready input stream carries
// a 2-bit destination select. Each beat lands in one of four single-entry
// holding registers, and each register has its own valid/ready handshake.
// Every channel also keeps a wrapping count of the beats it has delivered.
//
// Ordering is strict. A blocked selected channel stalls the whole input, even
// when other channels are empty. A channel that delivers and accepts in the
// same cycle reloads without a bubble.

module demux_1to4_reg #(
    parameter int BUS_WIDTH = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BUS_WIDTH-1:0] in_data,
    input  logic [1:0]           in_sel,

    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [BUS_WIDTH-1:0] out_data_a,
    output logic [BUS_WIDTH-1:0] out_data_b,
    output logic [BUS_WIDTH-1:0] out_data_c,
    output logic [BUS_WIDTH-1:0] out_data_d,

    output logic [CNT_WIDTH-1:0] count_a,
    output logic [CNT_WIDTH-1:0] count_b,
    output logic [CNT_WIDTH-1:0] count_c,
    output logic [CNT_WIDTH-1:0] count_d
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [3:0]           r_full;
    logic [BUS_WIDTH-1:0] r_data [4];
    logic [CNT_WIDTH-1:0] r_cnt  [4];

    logic                 w_in_ready;
    logic                 w_accept;
    logic [3:0]           w_deliver;
    logic [3:0]           w_wr_en;

    // The selected channel alone decides input readiness. in_valid is kept out
    // of this path on purpose, so that no combinational loop can form upstream.
    always_comb begin
        w_in_ready = !r_full[in_sel] || out_ready[in_sel];
    end

    // Handshake decode: any subset of channels may deliver in a cycle, but at
    // most one channel is written.
    always_comb begin
        w_accept  = in_valid && w_in_ready;
        w_deliver = r_full & out_ready;
        w_wr_en   = 4'b0000;
        if (w_accept) begin
            w_wr_en[in_sel] = 1'b1;
        end
    end

    // Full flags. A write wins over a delivery, so a simultaneous deliver and
    // accept keeps the channel full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 4'b0000;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_wr_en[k]) begin
                    r_full[k] <= 1'b1;
                end else if (w_deliver[k]) begin
                    r_full[k] <= 1'b0;
                end
            end
        end
    end

    // Holding data. It changes only on an accept into that channel and keeps
    // its last value after delivery.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_wr_en[k]) begin
                    r_data[k] <= in_data;
                end
            end
        end
    end

    // Delivered-beat counters. They wrap freely, with no saturation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_deliver[k]) begin
                    r_cnt[k] <= r_cnt[k] + CNT_ONE;
                end
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_full;
    assign out_data_a = r_data[0];
    assign out_data_b = r_data[1];
    assign out_data_c = r_data[2];
    assign out_data_d = r_data[3];
    assign count_a    = r_cnt[0];
    assign count_b    = r_cnt[1];
    assign count_c    = r_cnt[2];
    assign count_d    = r_cnt[3];

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Testbench for demux_1to4_reg: table-driven vectors plus hand-written reset
// and counter-wrap sequences. Counters are built 4 bits wide so that wrap
// is reachable.

module tb_demux_1to4_reg;

    localparam int BW = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_data = '0;
    logic [1:0]    in_sel = 2'd0;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready = 4'b0000;
    logic [BW-1:0] out_data_a, out_data_b, out_data_c, out_data_d;
    logic [CW-1:0] count_a, count_b, count_c, count_d;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    demux_1to4_reg #(.BUS_WIDTH(BW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data_a (out_data_a),
        .out_data_b (out_data_b),
        .out_data_c (out_data_c),
        .out_data_d (out_data_d),
        .count_a    (count_a),
        .count_b    (count_b),
        .count_c    (count_c),
        .count_d    (count_d)
    );

    typedef struct {
        logic       v;
        logic [1:0] sel;
        logic [3:0] d;
        logic [3:0] rdy;
        logic       ir;
        logic [3:0] ov;
        logic [3:0] da, db, dc, dd;
        logic [3:0] ca, cb, cc, cd;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ov,
                           input logic [3:0] da, input logic [3:0] db,
                           input logic [3:0] dc, input logic [3:0] dd,
                           input logic [3:0] ca, input logic [3:0] cb,
                           input logic [3:0] cc, input logic [3:0] cd);
        chk({tag, " out_valid"}, 16'(out_valid), 16'(ov));
        chk({tag, " data_a"},    16'(out_data_a), 16'(da));
        chk({tag, " data_b"},    16'(out_data_b), 16'(db));
        chk({tag, " data_c"},    16'(out_data_c), 16'(dc));
        chk({tag, " data_d"},    16'(out_data_d), 16'(dd));
        chk({tag, " count_a"},   16'(count_a), 16'(ca));
        chk({tag, " count_b"},   16'(count_b), 16'(cb));
        chk({tag, " count_c"},   16'(count_c), 16'(cc));
        chk({tag, " count_d"},   16'(count_d), 16'(cd));
    endtask

    initial begin
        //          v   sel  d     rdy    ir  ov       da    db    dc    dd    ca cb cc cd
        // basic routing, round robin, full rate
        tbl[0]  = '{1'b1, 2'd0, 4'h1, 4'b1111, 1'b1, 4'b0001, 4'h1, 4'h0, 4'h0, 4'h0, 4'd0, 4'd0, 4'd0, 4'd0};
        tbl[1]  = '{1'b1, 2'd1, 4'h2, 4'b1111, 1'b1, 4'b0010, 4'h1, 4'h2, 4'h0, 4'h0, 4'd1, 4'd0, 4'd0, 4'd0};
        tbl[2]  = '{1'b1, 2'd2, 4'h3, 4'b1111, 1'b1, 4'b0100, 4'h1, 4'h2, 4'h3, 4'h0, 4'd1, 4'd1, 4'd0, 4'd0};
        tbl[3]  = '{1'b1, 2'd3, 4'h4, 4'b1111, 1'b1, 4'b1000, 4'h1, 4'h2, 4'h3, 4'h4, 4'd1, 4'd1, 4'd1, 4'd0};
        tbl[4]  = '{1'b0, 2'd0, 4'h0, 4'b1111, 1'b1, 4'b0000, 4'h1, 4'h2, 4'h3, 4'h4, 4'd1, 4'd1, 4'd1, 4'd1};
        // backpressure on c, then deliver and reload with no bubble
        tbl[5]  = '{1'b1, 2'd2, 4'h5, 4'b1011, 1'b1, 4'b0100, 4'h1, 4'h2, 4'h5, 4'h4, 4'd1, 4'd1, 4'd1, 4'd1};
        tbl[6]  = '{1'b1, 2'd2, 4'h6, 4'b1011, 1'b0, 4'b0100, 4'h1, 4'h2, 4'h5, 4'h4, 4'd1, 4'd1, 4'd1, 4'd1};
        tbl[7]  = '{1'b1, 2'd2, 4'h6, 4'b1111, 1'b1, 4'b0100, 4'h1, 4'h2, 4'h6, 4'h4, 4'd1, 4'd1, 4'd2, 4'd1};
        tbl[8]  = '{1'b0, 2'd0, 4'h0, 4'b1111, 1'b1, 4'b0000, 4'h1, 4'h2, 4'h6, 4'h4, 4'd1, 4'd1, 4'd3, 4'd1};
        // head-of-line: d blocked, the held sel=3 beat keeps a starved
        tbl[9]  = '{1'b1, 2'd3, 4'h7, 4'b0111, 1'b1, 4'b1000, 4'h1, 4'h2, 4'h6, 4'h7, 4'd1, 4'd1, 4'd3, 4'd1};
        tbl[10] = '{1'b1, 2'd3, 4'h8, 4'b0111, 1'b0, 4'b1000, 4'h1, 4'h2, 4'h6, 4'h7, 4'd1, 4'd1, 4'd3, 4'd1};
        tbl[11] = '{1'b1, 2'd3, 4'h8, 4'b0111, 1'b0, 4'b1000, 4'h1, 4'h2, 4'h6, 4'h7, 4'd1, 4'd1, 4'd3, 4'd1};
        tbl[12] = '{1'b1, 2'd3, 4'h8, 4'b1111, 1'b1, 4'b1000, 4'h1, 4'h2, 4'h6, 4'h8, 4'd1, 4'd1, 4'd3, 4'd2};
        tbl[13] = '{1'b1, 2'd0, 4'h9, 4'b0111, 1'b1, 4'b1001, 4'h9, 4'h2, 4'h6, 4'h8, 4'd1, 4'd1, 4'd3, 4'd2};
        tbl[14] = '{1'b0, 2'd0, 4'h0, 4'b1111, 1'b1, 4'b0000, 4'h9, 4'h2, 4'h6, 4'h8, 4'd2, 4'd1, 4'd3, 4'd3};
        // fill all four with no ready, then drain all in one cycle
        tbl[15] = '{1'b1, 2'd0, 4'hA, 4'b0000, 1'b1, 4'b0001, 4'hA, 4'h2, 4'h6, 4'h8, 4'd2, 4'd1, 4'd3, 4'd3};
        tbl[16] = '{1'b1, 2'd1, 4'hB, 4'b0000, 1'b1, 4'b0011, 4'hA, 4'hB, 4'h6, 4'h8, 4'd2, 4'd1, 4'd3, 4'd3};
        tbl[17] = '{1'b1, 2'd2, 4'hC, 4'b0000, 1'b1, 4'b0111, 4'hA, 4'hB, 4'hC, 4'h8, 4'd2, 4'd1, 4'd3, 4'd3};
        tbl[18] = '{1'b1, 2'd3, 4'hD, 4'b0000, 1'b1, 4'b1111, 4'hA, 4'hB, 4'hC, 4'hD, 4'd2, 4'd1, 4'd3, 4'd3};
        tbl[19] = '{1'b0, 2'd0, 4'h0, 4'b1111, 1'b1, 4'b0000, 4'hA, 4'hB, 4'hC, 4'hD, 4'd3, 4'd2, 4'd4, 4'd4};

        // reset state
        #3;
        chk("reset in_ready", 16'(in_ready), 16'd1);
        chk_all("reset", 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'd0, 4'd0, 4'd0, 4'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            in_valid  = tbl[i].v;
            in_sel    = tbl[i].sel;
            in_data   = tbl[i].d;
            out_ready = tbl[i].rdy;
            #3;
            chk($sformatf("vec%0d in_ready", i), 16'(in_ready), 16'(tbl[i].ir));
            @(posedge clk); #1;
            chk_all($sformatf("vec%0d", i), tbl[i].ov, tbl[i].da, tbl[i].db,
                    tbl[i].dc, tbl[i].dd, tbl[i].ca, tbl[i].cb, tbl[i].cc, tbl[i].cd);
        end

        // asynchronous reset mid-cycle with channel b holding 4'hA
        in_valid  = 1'b1;
        in_sel    = 2'd1;
        in_data   = 4'hA;
        out_ready = 4'b0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre-rst out_valid", 16'(out_valid), 16'b0010);
        chk("pre-rst data_b", 16'(out_data_b), 16'hA);
        chk("pre-rst count_b", 16'(count_b), 16'd2);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async rst", 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 4'd0, 4'd0, 4'd0, 4'd0);
        chk("async rst in_ready", 16'(in_ready), 16'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // counter wrap: 17 back-to-back beats on channel a
        out_ready = 4'b1111;
        in_sel    = 2'd0;
        for (int e = 1; e <= 18; e++) begin
            in_valid = (e <= 17);
            in_data  = 4'(e);
            #3;
            chk($sformatf("wrap e%0d in_ready", e), 16'(in_ready), 16'd1);
            @(posedge clk); #1;
            chk($sformatf("wrap e%0d count_a", e), 16'(count_a), 16'((e - 1) % 16));
            chk($sformatf("wrap e%0d out_valid", e), 16'(out_valid), (e <= 17) ? 16'b0001 : 16'b0000);
            chk($sformatf("wrap e%0d others", e), 16'({count_b, count_c, count_d}), 16'd0);
        end
        chk("wrap final data_a", 16'(out_data_a), 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_1to4_reg.md
# demux_1to4_reg

Registered 1-to-4 stream demultiplexer: the inverse of the team's `mux_4to1`, for the datapath write-back/dispatch side. It accepts one valid/ready input stream carrying a 2-bit destination select. It routes each beat into one of four single-entry output holding registers, each with its own valid/ready handshake, and keeps a wrapping delivered-beat counter per channel.

## Interface
Parameters:
- BUS_WIDTH, 4, data width of the input and each output channel
- CNT_WIDTH, 8, width of each per-channel delivered-beat counter

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-high; clears all state immediately
- in_valid  input  1  input beat present
- in_ready  output  1  block can accept the input beat this cycle
- in_data  input  BUS_WIDTH  input payload
- in_sel  input  2  destination: 2'b00→a, 2'b01→b, 2'b10→c, 2'b11→d
- out_valid  output  4  per-channel holding register full; bit 0=a … bit 3=d
- out_ready  input  4  per-channel downstream ready; same bit order
- out_data_a / out_data_b / out_data_c / out_data_d  output  BUS_WIDTH  per-channel payload, meaningful only while the matching out_valid bit is 1
- count_a / count_b / count_c / count_d  output  CNT_WIDTH  beats delivered on each channel

## Operation
- Per channel k: one holding register (data, full flag). out_valid[k] = full[k].
- Delivery on channel k: out_valid[k] && out_ready[k] at a rising edge.
- in_ready is combinational: `!full[in_sel] || out_ready[in_sel]`.
  - It depends only on the selected channel.
  - It is independent of in_valid.
- Accept: in_valid && in_ready at a rising edge.
  - Writes in_data into register[in_sel].
  - Sets full[in_sel].
- Delivery without a simultaneous accept on the same channel clears full[k].
- Delivery plus accept on the same channel in the same cycle:
  - The register reloads with the new data.
  - full stays 1, so no bubble.
- Channels are independent. Any subset of channels may deliver in one cycle. At most one channel is written per cycle.
- A blocked selected channel stalls the input, even if other channels are empty. There is no reordering or bypass.
- Upstream rule: in_data and in_sel are held stable while in_valid && !in_ready. The block does not check this.
- The block never drops a beat and never overwrites a full register that is not being delivered that cycle.
- Counters:
  - count_k increments by 1 on each delivery on channel k.
  - Unsigned, wraps from 2^CNT_WIDTH−1 to 0.
  - No saturation. No overflow flag.
- out_data_k holds its last written value after delivery. The value is don't-care, but it must not change except on an accept into channel k.

## Timing
- Reset (async assert) values: out_valid=4'b0000, all out_data_*=0, all count_*=0. in_ready then evaluates to 1.
- Reset deassertion: the first accept can occur at the first rising edge after rst falls.
- Latency: a beat accepted at edge N is visible on out_valid[sel]/out_data_sel after edge N. It can be delivered at edge N+1 at the earliest.
- Throughput: 1 beat/cycle per channel when out_ready stays high. This holds both with a single channel and with round-robin selects.
- Count update: count_k changes at the same edge as the delivery. The new value is visible the cycle after the handshake.
- Reset mid-operation: all held beats are discarded and counters cleared asynchronously, with no waiting for a clock edge.
- Combinational paths:
  - out_ready → in_ready (one 4:1 select plus OR).
  - in_sel → in_ready.
  - No path from in_valid to in_ready.

## Test plan
- Reset check: assert rst mid-cycle with channel b full (data 4'hA) → out_valid goes to 0000 and count_b to 0 before the next edge; in_ready=1.
- Basic routing: out_ready=4'b1111; send 4'h1,4'h2,4'h3,4'h4 with sel 0,1,2,3 on consecutive cycles → each appears on a,b,c,d one cycle after accept; all four counters end at 1; in_ready stays 1 throughout.
- Backpressure stall: out_ready[2]=0; send 4'h5 sel=2, then 4'h6 sel=2.
  - Expected: first accepted; in_ready=0 while second presented; out_data_c holds 4'h5.
  - Then raise out_ready[2]: 4'h5 delivered and 4'h6 accepted in the same cycle; out_valid[2] stays 1 and out_data_c becomes 4'h6 with no bubble.
- Head-of-line: channel d full and blocked; present sel=3 then want sel=0 → in_ready=0 and channel a receives nothing until d drains.
- Simultaneous deliveries: fill all four channels with out_ready=0, then set out_ready=4'b1111 for one cycle → all out_valid clear at the same edge and every count increments by 1.
- Counter wrap: CNT_WIDTH=4; deliver 17 beats on channel a → count_a reads 15 after 15 beats, 0 after 16 and 1 after 17; other counters stay 0.
